// File: rtl/ama_riscv_alu_if.sv
// -----------------------------------------------------------------------------
// ama_riscv_alu_if
//   Operand/result bundle between the execute-stage issue logic and the ALU.
//
//   Signals
//     op_sel   [3:0]   operation select (driven by master)
//     in_a     [31:0]  operand A (driven by master)
//     in_b     [31:0]  operand B, shift amount in in_b[4:0] (driven by master)
//     out_s    [31:0]  combinational ALU result (driven by slave)
//     out_s_q  [31:0]  out_s registered on clk (driven by slave)
//
//   Modports
//     master : the side that issues operations and consumes results
//     slave  : the ALU itself
// -----------------------------------------------------------------------------
interface ama_riscv_alu_if;

    logic [3:0]  op_sel;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] out_s;
    logic [31:0] out_s_q;

    modport master (
        output op_sel,
        output in_a,
        output in_b,
        input  out_s,
        input  out_s_q
    );

    modport slave (
        input  op_sel,
        input  in_a,
        input  in_b,
        output out_s,
        output out_s_q
    );

endinterface : ama_riscv_alu_if

// File: rtl/ama_riscv_alu.sv
// -----------------------------------------------------------------------------
// ama_riscv_alu
//   32-bit RV32I integer ALU for the execute stage. Produces a zero-latency
//   combinational result (bus.out_s) and a one-cycle registered copy
//   (bus.out_s_q) for the next pipeline stage.
//
//   Ports
//     clk   input   rising-edge clock for the registered result
//     rst   input   asynchronous active-high reset, clears bus.out_s_q only
//     bus   slave   ama_riscv_alu_if: op_sel, in_a, in_b -> out_s, out_s_q
//
//   Structure
//     - One shared 33-bit adder serves ADD, SUB, SLT and SLTU. Compares are
//       derived from the subtraction's carry and sign bits.
//     - One right barrel shifter serves SRL, SRA and SLL. SLL reverses the
//       operand bits, shifts right with zero fill, and reverses back.
//     - Unused op_sel codes drive zero so nothing undefined leaks out.
// -----------------------------------------------------------------------------
module ama_riscv_alu (
    input  logic               clk,
    input  logic               rst,
    ama_riscv_alu_if.slave     bus
);

    // Operation encodings (op_sel)
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b1000;
    localparam logic [3:0] OP_SLL    = 4'b0001;
    localparam logic [3:0] OP_SRL    = 4'b0101;
    localparam logic [3:0] OP_SRA    = 4'b1101;
    localparam logic [3:0] OP_SLT    = 4'b0010;
    localparam logic [3:0] OP_SLTU   = 4'b0011;
    localparam logic [3:0] OP_XOR    = 4'b0100;
    localparam logic [3:0] OP_OR     = 4'b0110;
    localparam logic [3:0] OP_AND    = 4'b0111;
    localparam logic [3:0] OP_PASS_B = 4'b1111;

    // Mirror a word end-for-end so a right shifter can perform left shifts.
    function automatic logic [31:0] bit_reverse(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Adder / subtractor
    // ------------------------------------------------------------------
    logic        use_sub_s;
    logic [31:0] add_b_s;
    logic [32:0] sum_s;
    logic        ltu_s;
    logic        lt_s;

    // Select add vs. subtract; compares need a - b as well.
    always_comb begin
        use_sub_s = 1'b0;
        case (bus.op_sel)
            OP_SUB:  use_sub_s = 1'b1;
            OP_SLT:  use_sub_s = 1'b1;
            OP_SLTU: use_sub_s = 1'b1;
            default: use_sub_s = 1'b0;
        endcase
    end

    // Two's-complement subtract as a + ~b + 1; carry out survives in bit 32.
    always_comb begin
        add_b_s = 32'h0000_0000;
        if (use_sub_s) begin
            add_b_s = ~bus.in_b;
        end else begin
            add_b_s = bus.in_b;
        end
        sum_s = {1'b0, bus.in_a} + {1'b0, add_b_s} + {32'h0000_0000, use_sub_s};
    end

    // Unsigned a < b exactly when a - b borrows (no carry out). For signed,
    // differing signs decide directly; equal signs cannot overflow, so the
    // difference's sign bit is the answer.
    always_comb begin
        ltu_s = ~sum_s[32];
        lt_s  = 1'b0;
        if (bus.in_a[31] != bus.in_b[31]) begin
            lt_s = bus.in_a[31];
        end else begin
            lt_s = sum_s[31];
        end
    end

    // ------------------------------------------------------------------
    // Shared barrel shifter
    // ------------------------------------------------------------------
    logic [4:0]  shamt_s;
    logic        shift_fill_s;
    logic [31:0] shift_src_s;
    logic [31:0] stage1_s;
    logic [31:0] stage2_s;
    logic [31:0] stage4_s;
    logic [31:0] stage8_s;
    logic [31:0] stage16_s;
    logic [31:0] shl_s;

    // Choose shifter input orientation and fill bit for the current op.
    always_comb begin
        shamt_s      = bus.in_b[4:0];
        shift_fill_s = 1'b0;
        shift_src_s  = bus.in_a;
        case (bus.op_sel)
            OP_SLL: begin
                shift_fill_s = 1'b0;
                shift_src_s  = bit_reverse(bus.in_a);
            end
            OP_SRA: begin
                shift_fill_s = bus.in_a[31];
                shift_src_s  = bus.in_a;
            end
            default: begin
                shift_fill_s = 1'b0;
                shift_src_s  = bus.in_a;
            end
        endcase
    end

    // Logarithmic right shift: each stage conditionally shifts by a power of two.
    always_comb begin
        if (shamt_s[0]) begin
            stage1_s = {shift_fill_s, shift_src_s[31:1]};
        end else begin
            stage1_s = shift_src_s;
        end
        if (shamt_s[1]) begin
            stage2_s = {{2{shift_fill_s}}, stage1_s[31:2]};
        end else begin
            stage2_s = stage1_s;
        end
        if (shamt_s[2]) begin
            stage4_s = {{4{shift_fill_s}}, stage2_s[31:4]};
        end else begin
            stage4_s = stage2_s;
        end
        if (shamt_s[3]) begin
            stage8_s = {{8{shift_fill_s}}, stage4_s[31:8]};
        end else begin
            stage8_s = stage4_s;
        end
        if (shamt_s[4]) begin
            stage16_s = {{16{shift_fill_s}}, stage8_s[31:16]};
        end else begin
            stage16_s = stage8_s;
        end
        shl_s = bit_reverse(stage16_s);
    end

    // ------------------------------------------------------------------
    // Result select and pipeline register
    // ------------------------------------------------------------------
    logic [31:0] result_d;
    logic [31:0] result_q;

    // Final result mux; reserved encodings resolve to zero.
    always_comb begin
        result_d = 32'h0000_0000;
        case (bus.op_sel)
            OP_ADD:    result_d = sum_s[31:0];
            OP_SUB:    result_d = sum_s[31:0];
            OP_SLL:    result_d = shl_s;
            OP_SRL:    result_d = stage16_s;
            OP_SRA:    result_d = stage16_s;
            OP_SLT:    result_d = {31'h0000_0000, lt_s};
            OP_SLTU:   result_d = {31'h0000_0000, ltu_s};
            OP_XOR:    result_d = bus.in_a ^ bus.in_b;
            OP_OR:     result_d = bus.in_a | bus.in_b;
            OP_AND:    result_d = bus.in_a & bus.in_b;
            OP_PASS_B: result_d = bus.in_b;
            default:   result_d = 32'h0000_0000;
        endcase
    end

    // One-cycle copy of the result for the next stage; reset clears it at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= 32'h0000_0000;
        end else begin
            result_q <= result_d;
        end
    end

    assign bus.out_s   = result_d;
    assign bus.out_s_q = result_q;

endmodule : ama_riscv_alu

// File: tb/tb_ama_riscv_alu.sv
// -----------------------------------------------------------------------------
// tb_ama_riscv_alu
//   Self-checking bench for ama_riscv_alu: directed vector table, random
//   vectors against an arithmetic reference model, and registered-output /
//   asynchronous reset sequences.
// -----------------------------------------------------------------------------
module tb_ama_riscv_alu;

    logic clk;
    logic rst;

    ama_riscv_alu_if alu_bus ();

    ama_riscv_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (alu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        alu_bus.op_sel = op;
        alu_bus.in_a   = a;
        alu_bus.in_b   = b;
    endtask

    // Reference model built from plain integer arithmetic on 64-bit values.
    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        longint d;
        longint r;
        int     sh;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(ub % 64'd32);
        d  = 64'd1;
        for (int i = 0; i < sh; i++) d = d * 64'd2;
        case (op)
            4'd0:    r = ua + ub;
            4'd8:    r = ua - ub;
            4'd1:    r = ua * d;
            4'd5:    r = ua / d;
            4'd13:   r = (sa >= 64'sd0) ? sa / d : -((-sa + d - 64'd1) / d);
            4'd2:    r = (sa < sb) ? 64'd1 : 64'd0;
            4'd3:    r = (ua < ub) ? 64'd1 : 64'd0;
            4'd4:    r = ua ^ ub;
            4'd6:    r = ua | ub;
            4'd7:    r = ua & ub;
            4'd15:   r = ub;
            default: r = 64'd0;
        endcase
        return r[31:0];
    endfunction

    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] exp_q;

    initial begin
        rst = 1'b0;
        drive(4'd0, 32'd0, 32'd0);
        #1 rst = 1'b1;
        #1 check("reset_out_s_q", alu_bus.out_s_q, 32'h0);

        // Directed vectors
        add_vec("add",        4'b0000, 32'd16,        32'd11,        32'd27);
        add_vec("add_wrap",   4'b0000, 32'hFFFF_FFFF, 32'd2,         32'd1);
        add_vec("sub",        4'b1000, 32'd17,        32'd10,        32'd7);
        add_vec("sub_wrap",   4'b1000, 32'd0,         32'd1,         32'hFFFF_FFFF);
        add_vec("pass_b",     4'b1111, 32'd35,        32'd192,       32'd192);
        add_vec("inv_9",      4'b1001, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
        add_vec("inv_a",      4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        add_vec("inv_b",      4'b1011, 32'd5,         32'd7,         32'h0);
        add_vec("inv_c",      4'b1100, 32'h8000_0000, 32'd1,         32'h0);
        add_vec("inv_e",      4'b1110, 32'd1,         32'd1,         32'h0);
        add_vec("srl",        4'b0101, 32'd35,        32'd4,         32'd2);
        add_vec("sra",        4'b1101, 32'd35,        32'd4,         32'd2);
        add_vec("sll",        4'b0001, 32'd35,        32'd4,         32'd560);
        add_vec("sra_neg",    4'b1101, 32'h8000_0000, 32'h24,        32'hF800_0000);
        add_vec("srl_neg",    4'b0101, 32'h8000_0000, 32'h24,        32'h0800_0000);
        add_vec("sll_0",      4'b0001, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF);
        add_vec("sra_0",      4'b1101, 32'h8765_4321, 32'd0,         32'h8765_4321);
        add_vec("sll_31",     4'b0001, 32'd1,         32'd31,        32'h8000_0000);
        add_vec("srl_31",     4'b0101, 32'h8000_0000, 32'd31,        32'd1);
        add_vec("sra_31",     4'b1101, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF);
        add_vec("slt_neg",    4'b0010, 32'hFFFF_FFFF, 32'd1,         32'd1);
        add_vec("sltu_big",   4'b0011, 32'hFFFF_FFFF, 32'd1,         32'd0);
        add_vec("slt_eq",     4'b0010, 32'd42,        32'd42,        32'd0);
        add_vec("sltu_eq",    4'b0011, 32'd42,        32'd42,        32'd0);
        add_vec("slt_pos",    4'b0010, 32'd5,         32'hFFFF_FFFD, 32'd0);
        add_vec("sltu_small", 4'b0011, 32'd1,         32'hFFFF_FFFF, 32'd1);
        add_vec("xor",        4'b0100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
        add_vec("or",         4'b0110, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
        add_vec("and",        4'b0111, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            #1 check(vecs[i].name, alu_bus.out_s, vecs[i].exp);
        end

        // out_s_q must stay cleared while rst is high, whatever out_s does
        check("reset_hold", alu_bus.out_s_q, 32'h0);

        // Random vectors, invalid opcodes included
        for (int i = 0; i < 100; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            r_b  = $urandom;
            if (i % 8 == 0) r_b = r_a;
            drive(r_op, r_a, r_b);
            #1 check($sformatf("rand_%0d_op%0d", i, r_op), alu_bus.out_s,
                     ref_alu(r_op, r_a, r_b));
        end

        // Registered output: one-cycle latency after reset release
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            r_op  = 4'($urandom_range(0, 15));
            r_a   = $urandom;
            r_b   = $urandom;
            drive(r_op, r_a, r_b);
            exp_q = ref_alu(r_op, r_a, r_b);
            @(posedge clk);
            #1 check($sformatf("reg_%0d", i), alu_bus.out_s_q, exp_q);
        end

        // Mid-cycle asynchronous reset: clears out_s_q at once, out_s unaffected
        drive(4'b0000, 32'd100, 32'd23);
        @(posedge clk);
        #1 check("reg_before_rst", alu_bus.out_s_q, 32'd123);
        #2 rst = 1'b1;
        #1 check("async_rst_clear", alu_bus.out_s_q, 32'h0);
        check("rst_no_effect_out_s", alu_bus.out_s, 32'd123);
        @(posedge clk);
        #1 check("rst_hold_edge", alu_bus.out_s_q, 32'h0);
        rst = 1'b0;
        drive(4'b0001, 32'h0000_0003, 32'd8);
        #1 check("after_rst_pre_edge", alu_bus.out_s_q, 32'h0);
        @(posedge clk);
        #1 check("after_rst_capture", alu_bus.out_s_q, 32'h0000_0300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ama_riscv_alu
